l3_bank_arbiter: RTL and testbench
==================================

Name: l3_bank_arbiter

Overview:
- Shares the single central L3 cell array among the core datapath blocks.
- Arbitrates requests round-robin and runs one L3 access at a time with a fixed access latency.
- Returns a one-cycle response to the winning requester.
- Sits between the per-core datapath blocks and the L3 grid, inside the chip top.

Parameters:
NUM_REQ, 6, number of requesters (one per core)
ADDR_W, 12, L3 cell address width (row*60+col)
DATA_W, 16, L3 cell data width
MAX_ADDR, 3599, highest legal cell address (60x60 grid)
ACCESS_CYCLES, 3, cycles l3_en is held per access (legal range 1..15)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-requester request valid
req_ready  out  NUM_REQ  one-hot grant/accept
req_we  in  NUM_REQ  1=write, 0=read
req_addr  in  NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_REQ*DATA_W  packed write data
rsp_valid  out  NUM_REQ  one-hot response pulse
rsp_rdata  out  DATA_W  read data (0 for writes/errors)
rsp_err  out  1  address out of range, qualified by any rsp_valid
l3_en  out  1  L3 access strobe
l3_we  out  1  L3 write enable
l3_addr  out  ADDR_W  L3 address
l3_wdata  out  DATA_W  L3 write data
l3_rdata  in  DATA_W  L3 read data, valid while l3_en
busy  out  1  high in any state except IDLE

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE, all outputs 0.
  - Last-grant pointer ptr=NUM_REQ-1, so requester 0 has first priority.
  - Latched request regs and counter cleared.
  - Reset mid-access aborts the access; no rsp_valid is produced.
- FSM states IDLE, ACCESS, RESP.
- IDLE arbitration:
  - req_ready is combinational and one-hot: the first requester with req_valid=1 scanning ptr+1, ptr+2, ... modulo NUM_REQ.
  - req_ready is all-zero if there is no request, and all-zero outside IDLE.
- Handshake: req_valid[i] & req_ready[i] at edge T.
  - Latch addr/we/wdata and index g.
  - If addr <= MAX_ADDR: go to ACCESS with cnt=ACCESS_CYCLES-1.
  - Else: set err flag and go directly to RESP. No l3_en is issued.
- Requester obligations: hold addr/we/wdata stable while valid and not ready. A requester may drop valid before ready; the arbiter then re-evaluates the same cycle.
- ACCESS state:
  - l3_en=1; l3_we/addr/wdata driven from latched regs. These are registered outputs, stable for ACCESS_CYCLES consecutive cycles.
  - cnt decrements each cycle.
  - When cnt==0, capture l3_rdata (reads only; writes capture 0) and go to RESP.
- RESP state (one cycle):
  - rsp_valid[g]=1, rsp_rdata=captured data, rsp_err=err.
  - Next: IDLE, ptr=g, err cleared.
  - IDLE arbitration resumes the following cycle. Back-to-back transactions have one IDLE cycle between them.
- Latency: handshake at cycle T.
  - l3_en high for cycles T+1..T+ACCESS_CYCLES.
  - rsp_valid at T+ACCESS_CYCLES+1.
  - Error case: rsp_valid at T+1.
- Fairness: with all requesters continuously valid, grants rotate 0,1,...,NUM_REQ-1,0. Any requester waits at most NUM_REQ-1 transactions.
- Arithmetic: ptr and index wrap modulo NUM_REQ (not power of two; explicit compare-and-wrap). cnt is 4 bits.
- Simultaneous events: a new req_valid arriving during ACCESS/RESP waits and is not dropped. A requester may re-request the cycle after its own rsp_valid; it is then ordered after other pending requesters.
- rsp_rdata and rsp_err hold 0 whenever rsp_valid is all-zero.

Test Plan:
- Reset then single read: req_valid=6'b000100, addr=5, l3_rdata=16'hA5A5 → req_ready=6'b000100 at T; l3_en T+1..T+3 with l3_addr=5, l3_we=0; rsp_valid=6'b000100, rsp_rdata=A5A5, rsp_err=0 at T+4.
- Write: requester 0, addr=3599, wdata=16'h1234 → l3_we=1, l3_wdata=1234 for 3 cycles; rsp_valid[0] at T+4 with rsp_rdata=0.
- Out of range: requester 5, addr=3600 → no l3_en; rsp_valid=6'b100000, rsp_err=1 at T+1; busy low again at T+2.
- All six requesting continuously from reset → grant order 0,1,2,3,4,5,0; each transaction spans 5 cycles (grant, 3 access, resp), so grants land at cycles 0,5,10,...
- Mid-access reset: assert rst_n=0 during the second l3_en cycle → all outputs 0 immediately, no rsp_valid. After release, requesters 3 and 0 valid → requester 0 granted first.
- Withdrawal: requester 2 raises valid and drops it while requester 1 is in ACCESS → requester 2 is never granted or responded to; requester 4 requesting afterward is granted normally.

Source files
------------

// File: rtl/l3_bank_arbiter.sv
// Round-robin arbiter sharing the central L3 cell array among the core datapath blocks.
// One access is in flight at a time, followed by a single-cycle response to the winner.
//
// state  | meaning
// IDLE   | arbitrate; req_ready is the one-hot winner scanning from ptr+1
// ACCESS | l3_en held for ACCESS_CYCLES cycles, cnt counts down to zero
// RESP   | one-cycle rsp_valid to the latched winner, then ptr moves to it
module l3_bank_arbiter #(
  parameter int NUM_REQ       = 6,
  parameter int ADDR_W        = 12,
  parameter int DATA_W        = 16,
  parameter int MAX_ADDR      = 3599,
  parameter int ACCESS_CYCLES = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_we,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      rsp_err,
  output logic                      l3_en,
  output logic                      l3_we,
  output logic [ADDR_W-1:0]         l3_addr,
  output logic [DATA_W-1:0]         l3_wdata,
  input  logic [DATA_W-1:0]         l3_rdata,
  output logic                      busy
);

  localparam int PTR_W = $clog2(NUM_REQ);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t             state, state_nxt;
  logic [PTR_W-1:0]   ptr;
  logic [PTR_W-1:0]   gnt;
  logic [PTR_W-1:0]   gnt_nxt;
  logic [PTR_W-1:0]   idx_p;
  logic               found;
  logic [NUM_REQ-1:0] grant;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               sel_we;
  logic               addr_ok;
  logic [3:0]         cnt;
  logic               err;
  logic [DATA_W-1:0]  rdata_q;

  // Scan ptr+1 .. ptr+NUM_REQ with explicit wrap since NUM_REQ need not be a power of two.
  always_comb begin
    int idx;
    idx     = 0;
    idx_p   = '0;
    grant   = '0;
    gnt_nxt = '0;
    found   = 1'b0;
    if (state == IDLE) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        if (int'(ptr) + k >= NUM_REQ) idx = int'(ptr) + k - NUM_REQ;
        else                          idx = int'(ptr) + k;
        idx_p = PTR_W'(idx);
        if (!found && req_valid[idx_p]) begin
          found   = 1'b1;
          gnt_nxt = idx_p;
        end
      end
      if (found) grant[gnt_nxt] = 1'b1;
    end
  end

  assign sel_addr  = req_addr[gnt_nxt*ADDR_W +: ADDR_W];
  assign sel_wdata = req_wdata[gnt_nxt*DATA_W +: DATA_W];
  assign sel_we    = req_we[gnt_nxt];
  assign addr_ok   = (sel_addr <= ADDR_W'(MAX_ADDR));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (found) state_nxt = addr_ok ? ACCESS : RESP;
      ACCESS:  if (cnt == 4'd0) state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr      <= PTR_W'(NUM_REQ - 1);
      gnt      <= '0;
      cnt      <= '0;
      err      <= 1'b0;
      rdata_q  <= '0;
      l3_en    <= 1'b0;
      l3_we    <= 1'b0;
      l3_addr  <= '0;
      l3_wdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            gnt <= gnt_nxt;
            if (addr_ok) begin
              l3_en    <= 1'b1;
              l3_we    <= sel_we;
              l3_addr  <= sel_addr;
              l3_wdata <= sel_wdata;
              cnt      <= 4'(ACCESS_CYCLES - 1);
            end else begin
              err <= 1'b1;
            end
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            rdata_q  <= l3_we ? '0 : l3_rdata;
            l3_en    <= 1'b0;
            l3_we    <= 1'b0;
            l3_addr  <= '0;
            l3_wdata <= '0;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          ptr     <= gnt;
          err     <= 1'b0;
          rdata_q <= '0;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (state == RESP) rsp_valid[gnt] = 1'b1;
  end

  assign req_ready = grant;
  assign rsp_rdata = (state == RESP) ? rdata_q : '0;
  assign rsp_err   = (state == RESP) && err;
  assign busy      = (state != IDLE);

endmodule

// File: tb/tb_l3_bank_arbiter.sv
// Directed bench for l3_bank_arbiter: latency, errors, rotation, reset abort, withdrawal.
module tb_l3_bank_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  req_valid, req_ready, req_we, rsp_valid;
  logic [71:0] req_addr;
  logic [95:0] req_wdata;
  logic [15:0] rsp_rdata, l3_wdata, l3_rdata;
  logic        rsp_err, l3_en, l3_we, busy;
  logic [11:0] l3_addr;

  int n_checks = 0;
  int n_errors = 0;

  l3_bank_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .l3_en(l3_en), .l3_we(l3_we), .l3_addr(l3_addr), .l3_wdata(l3_wdata),
    .l3_rdata(l3_rdata), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic set_req(input int i, input logic we, input logic [11:0] a, input logic [15:0] d);
    req_we[i]              = we;
    req_addr[i*12 +: 12]   = a;
    req_wdata[i*16 +: 16]  = d;
  endtask

  initial begin
    req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    l3_rdata  = 16'hA5A5;
    #12;
    check("rst_ready", 32'(req_ready), 0);
    check("rst_rsp",   32'(rsp_valid), 0);
    check("rst_l3en",  32'(l3_en), 0);
    check("rst_busy",  32'(busy), 0);
    check("rst_rdata", 32'(rsp_rdata), 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // single read by requester 2
    set_req(2, 1'b0, 12'd5, 16'h0);
    req_valid = 6'b000100;
    #1;
    check("rd_ready", 32'(req_ready), 'h04);
    check("rd_busy0", 32'(busy), 0);
    tick();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("rd_l3en",  32'(l3_en), 1);
      check("rd_addr",  32'(l3_addr), 5);
      check("rd_we",    32'(l3_we), 0);
      check("rd_rdy_busy", 32'(req_ready), 0);
      tick();
    end
    #1;
    check("rd_rsp",    32'(rsp_valid), 'h04);
    check("rd_rdata",  32'(rsp_rdata), 'hA5A5);
    check("rd_err",    32'(rsp_err), 0);
    check("rd_l3en_off", 32'(l3_en), 0);
    tick();
    #1;
    check("rd_rsp_end",  32'(rsp_valid), 0);
    check("rd_busy_end", 32'(busy), 0);
    check("rd_rdata_end", 32'(rsp_rdata), 0);

    // write by requester 0 at the highest legal address
    set_req(0, 1'b1, 12'd3599, 16'h1234);
    req_valid = 6'b000001;
    #1;
    check("wr_ready", 32'(req_ready), 'h01);
    tick();
    req_valid = '0;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("wr_l3en",  32'(l3_en), 1);
      check("wr_we",    32'(l3_we), 1);
      check("wr_wdata", 32'(l3_wdata), 'h1234);
      check("wr_addr",  32'(l3_addr), 3599);
      tick();
    end
    #1;
    check("wr_rsp",   32'(rsp_valid), 'h01);
    check("wr_rdata", 32'(rsp_rdata), 0);
    tick();

    // out-of-range address from requester 5
    set_req(5, 1'b0, 12'd3600, 16'h0);
    req_valid = 6'b100000;
    #1;
    check("oor_ready", 32'(req_ready), 'h20);
    tick();
    req_valid = '0;
    #1;
    check("oor_l3en",  32'(l3_en), 0);
    check("oor_rsp",   32'(rsp_valid), 'h20);
    check("oor_err",   32'(rsp_err), 1);
    check("oor_rdata", 32'(rsp_rdata), 0);
    check("oor_busy",  32'(busy), 1);
    tick();
    #1;
    check("oor_busy_end", 32'(busy), 0);
    check("oor_err_end",  32'(rsp_err), 0);
    check("oor_rsp_end",  32'(rsp_valid), 0);

    // all six requesting continuously from reset
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) set_req(i, 1'b0, 12'(i * 10), 16'h0);
    l3_rdata  = 16'hBEEF;
    req_valid = 6'b111111;
    for (int t = 0; t < 7; t++) begin
      #1;
      check("rr_ready", 32'(req_ready), 32'(1) << (t % 6));
      tick();
      for (int c = 0; c < 3; c++) begin
        #1;
        check("rr_addr", 32'(l3_addr), 32'((t % 6) * 10));
        tick();
      end
      #1;
      check("rr_rsp",   32'(rsp_valid), 32'(1) << (t % 6));
      check("rr_rdata", 32'(rsp_rdata), 'hBEEF);
      tick();
    end
    req_valid = '0;

    // reset during the second access cycle
    set_req(2, 1'b0, 12'd7, 16'h0);
    req_valid = 6'b000100;
    #1;
    check("ab_ready", 32'(req_ready), 'h04);
    tick();
    req_valid = '0;
    #1;
    check("ab_l3en1", 32'(l3_en), 1);
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    check("ab_l3en",  32'(l3_en), 0);
    check("ab_addr",  32'(l3_addr), 0);
    check("ab_busy",  32'(busy), 0);
    check("ab_rsp",   32'(rsp_valid), 0);
    check("ab_ready0", 32'(req_ready), 0);
    tick();
    tick();
    #1;
    check("ab_rsp_hold", 32'(rsp_valid), 0);
    rst_n = 1'b1;
    set_req(3, 1'b0, 12'd9, 16'h0);
    set_req(0, 1'b0, 12'd11, 16'h0);
    req_valid = 6'b001001;
    #1;
    check("ab_first", 32'(req_ready), 'h01);
    tick();
    req_valid = 6'b001000;
    tick(); tick(); tick();
    #1;
    check("ab_rsp0", 32'(rsp_valid), 'h01);
    tick();
    #1;
    check("ab_second", 32'(req_ready), 'h08);
    tick();
    req_valid = '0;
    #1;
    check("ab_addr3", 32'(l3_addr), 9);
    tick(); tick(); tick();
    #1;
    check("ab_rsp3", 32'(rsp_valid), 'h08);
    tick();

    // requester 2 withdraws while requester 1 is in ACCESS
    set_req(1, 1'b0, 12'd20, 16'h0);
    set_req(2, 1'b0, 12'd21, 16'h0);
    set_req(4, 1'b0, 12'd22, 16'h0);
    req_valid = 6'b000010;
    #1;
    check("wd_ready1", 32'(req_ready), 'h02);
    tick();
    req_valid = 6'b000100;
    #1;
    check("wd_ready_acc", 32'(req_ready), 0);
    check("wd_addr1", 32'(l3_addr), 20);
    tick();
    req_valid = '0;
    tick();
    tick();
    #1;
    check("wd_rsp1", 32'(rsp_valid), 'h02);
    tick();
    req_valid = 6'b010000;
    #1;
    check("wd_ready4", 32'(req_ready), 'h10);
    tick();
    req_valid = '0;
    #1;
    check("wd_addr4", 32'(l3_addr), 22);
    tick(); tick(); tick();
    #1;
    check("wd_rsp4", 32'(rsp_valid), 'h10);
    tick();
    #1;
    check("wd_idle", 32'(busy), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
